seven_seg_capture: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 43 ++++
 rtl/seven_seg_decode.sv | 33 +++
 rtl/seven_seg_capture.sv | 158 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared seven-segment types and the hex glyph table. The
//                encoder and the decoder both use seg_encode(), so the two
//                tables cannot diverge.
//                Segment order: bit0=a .. bit6=g, active-high (lit = 1).
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    typedef logic [6:0] seven_seg_t;

    localparam seven_seg_t SEG_BLANK = 7'h00;

    // Canonical glyph for each hex nibble. Lowercase 'b' and 'd' keep them
    // distinguishable from '8' and '0'.
    function automatic seven_seg_t seg_encode(input logic [3:0] nibble);
        seven_seg_t seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_decode
//  Description : Combinational inverse of the seven-segment encoder.
//                Any pattern that is not one of the 16 hex glyphs (blank
//                included) yields nibble 0 with o_valid low.
//  Ports       : i_seg    - segment pattern (bit0=a .. bit6=g)
//                o_nibble - decoded hex value
//                o_valid  - pattern matched a known glyph
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  seven_seg_t  i_seg,
    output logic [3:0]  o_nibble,
    output logic        o_valid
);

    // Search the shared encode table so both directions stay consistent.
    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == seg_encode(4'(i))) begin
                o_nibble = 4'(i);
                o_valid  = 1'b1;
            end
        end
    end

endmodule : seven_seg_decode
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_capture
//  Description : Receiver for a multiplexed seven-segment bus. Registers the
//                segment / digit-select pair, waits for SETTLE_CYCLES
//                identical samples, decodes the glyph into the selected
//                nibble slot and publishes the assembled value once every
//                digit of the frame has been captured.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                seg_in      - segment pattern (bit0=a .. bit6=g)
//                digit_sel   - one-hot digit enable, bit i -> nibble i
//                dout        - assembled value, digit i at [4i+3:4i]
//                dout_valid  - one-cycle pulse when outputs update
//                dout_err    - frame had a bad glyph or multi-hot select
//                err_mask    - per-digit bad-glyph flags of reported frame
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_COUNT   = 2,
    parameter int SETTLE_CYCLES = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  seven_seg_t                 seg_in,
    input  logic [DIGIT_COUNT-1:0]     digit_sel,
    output logic [4*DIGIT_COUNT-1:0]   dout,
    output logic                       dout_valid,
    output logic                       dout_err,
    output logic [DIGIT_COUNT-1:0]     err_mask
);

    localparam logic [7:0]             C_SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [DIGIT_COUNT-1:0] C_SEL_ONE = DIGIT_COUNT'(1);

    // Input stage and the previous registered pair
    seven_seg_t               r_s_seg;
    seven_seg_t               r_p_seg;
    logic [DIGIT_COUNT-1:0]   r_s_sel;
    logic [DIGIT_COUNT-1:0]   r_p_sel;
    logic [7:0]               r_run_cnt;

    // Frame accumulation
    logic [4*DIGIT_COUNT-1:0] r_buf;
    logic [DIGIT_COUNT-1:0]   r_frame_mask;
    logic [DIGIT_COUNT-1:0]   r_frame_err;
    logic                     r_frame_sel_err;

    // Output registers
    logic [4*DIGIT_COUNT-1:0] r_dout;
    logic                     r_dout_valid;
    logic                     r_dout_err;
    logic [DIGIT_COUNT-1:0]   r_err_mask;

    logic                     w_same;
    logic [7:0]               w_cnt_next;
    logic                     w_accept;
    logic                     w_sel_nz;
    logic                     w_sel_onehot;
    logic                     w_sel_multi;
    logic [3:0]               w_nibble;
    logic                     w_glyph_ok;
    logic                     w_complete;
    logic [4*DIGIT_COUNT-1:0] w_buf_next;
    logic [DIGIT_COUNT-1:0]   w_mask_next;
    logic [DIGIT_COUNT-1:0]   w_err_next;
    logic                     w_sel_err_next;

    seven_seg_decode u_decode (
        .i_seg    (r_s_seg),
        .o_nibble (w_nibble),
        .o_valid  (w_glyph_ok)
    );

    // Run length of the current registered pair, saturating at SETTLE.
    assign w_same     = (r_s_seg == r_p_seg) && (r_s_sel == r_p_sel);
    assign w_cnt_next = !w_same                 ? 8'd1     :
                        (r_run_cnt >= C_SETTLE) ? C_SETTLE :
                                                  r_run_cnt + 8'd1;

    // Accept only on the transition into SETTLE: a run already sitting at
    // SETTLE is not accepted again. A changed pair restarts at 1, so with
    // SETTLE_CYCLES=1 every change is accepted.
    assign w_accept   = (w_cnt_next == C_SETTLE) &&
                        !(w_same && (r_run_cnt == C_SETTLE));

    assign w_sel_nz     = (r_s_sel != '0);
    assign w_sel_onehot = w_sel_nz && ((r_s_sel & (r_s_sel - C_SEL_ONE)) == '0);
    assign w_sel_multi  = w_sel_nz && !w_sel_onehot;

    assign w_complete   = &r_frame_mask;

    always_comb begin
        w_buf_next     = r_buf;
        w_mask_next    = r_frame_mask;
        w_err_next     = r_frame_err;
        w_sel_err_next = r_frame_sel_err;
        if (w_accept && w_sel_onehot) begin
            for (int i = 0; i < DIGIT_COUNT; i++) begin
                if (r_s_sel[i]) begin
                    w_buf_next[4*i +: 4] = w_nibble;
                    w_mask_next[i]       = 1'b1;
                    w_err_next[i]        = !w_glyph_ok;
                end
            end
        end
        if (w_accept && w_sel_multi) begin
            w_sel_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_seg         <= SEG_BLANK;
            r_p_seg         <= SEG_BLANK;
            r_s_sel         <= '0;
            r_p_sel         <= '0;
            r_run_cnt       <= 8'd0;
            r_buf           <= '0;
            r_frame_mask    <= '0;
            r_frame_err     <= '0;
            r_frame_sel_err <= 1'b0;
            r_dout          <= '0;
            r_dout_valid    <= 1'b0;
            r_dout_err      <= 1'b0;
            r_err_mask      <= '0;
        end else begin
            r_s_seg      <= seg_in;
            r_s_sel      <= digit_sel;
            r_p_seg      <= r_s_seg;
            r_p_sel      <= r_s_sel;
            r_run_cnt    <= w_cnt_next;
            r_buf        <= w_buf_next;
            r_dout_valid <= w_complete;
            if (w_complete) begin
                // Report includes anything accepted on this same edge.
                r_dout          <= w_buf_next;
                r_err_mask      <= w_err_next;
                r_dout_err      <= (|w_err_next) | w_sel_err_next;
                r_frame_mask    <= '0;
                r_frame_err     <= '0;
                r_frame_sel_err <= 1'b0;
            end else begin
                r_frame_mask    <= w_mask_next;
                r_frame_err     <= w_err_next;
                r_frame_sel_err <= w_sel_err_next;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_err   = r_dout_err;
    assign err_mask   = r_err_mask;

endmodule : seven_seg_capture
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_capture
//  Description : Self-checking bench for seven_seg_capture (2 digits,
//                settle of 4). Frame table plus hand-written sequences for
//                reset, latency and reset/completion interaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    localparam int DC = 2;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    seven_seg_t    seg_in;
    logic [DC-1:0] digit_sel;
    logic [4*DC-1:0] dout;
    logic          dout_valid;
    logic          dout_err;
    logic [DC-1:0] err_mask;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_total = 0;

    typedef struct {
        string      name;
        logic [1:0] sel0; logic [6:0] seg0; int n0;
        logic [1:0] sel1; logic [6:0] seg1; int n1;
        logic [1:0] sel2; logic [6:0] seg2; int n2;
        logic [7:0] exp_dout;
        logic       exp_err;
        logic [1:0] exp_mask;
        int         exp_pulses;
    } frame_vec_t;

    frame_vec_t vecs [8];

    seven_seg_capture #(
        .DIGIT_COUNT   (DC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .digit_sel  (digit_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_err   (dout_err),
        .err_mask   (err_mask)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) pulse_total <= pulse_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the pair and waits n falling edges.
    task automatic hold(input logic [1:0] s, input logic [6:0] g, input int n);
        digit_sel = s;
        seg_in    = g;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;

        vecs[0] = '{"normal",   2'b01, 7'h5B, 6,  2'b10, 7'h4F, 6,  2'b10, 7'h4F, 6, 8'h32, 1'b0, 2'b00, 1};
        vecs[1] = '{"glitch",   2'b01, 7'h06, 3,  2'b01, 7'h7F, 5,  2'b10, 7'h66, 5, 8'h48, 1'b0, 2'b00, 1};
        vecs[2] = '{"invalid",  2'b01, 7'h6D, 5,  2'b10, 7'h00, 5,  2'b10, 7'h00, 1, 8'h05, 1'b1, 2'b10, 1};
        vecs[3] = '{"clean",    2'b01, 7'h3F, 6,  2'b10, 7'h3F, 6,  2'b10, 7'h3F, 1, 8'h00, 1'b0, 2'b00, 1};
        vecs[4] = '{"multihot", 2'b11, 7'h7F, 10, 2'b01, 7'h06, 6,  2'b10, 7'h06, 6, 8'h11, 1'b1, 2'b00, 1};
        vecs[5] = '{"selclr",   2'b01, 7'h77, 6,  2'b10, 7'h7C, 6,  2'b10, 7'h7C, 1, 8'hBA, 1'b0, 2'b00, 1};
        vecs[6] = '{"order",    2'b10, 7'h39, 6,  2'b01, 7'h5E, 6,  2'b01, 7'h5E, 1, 8'hCD, 1'b0, 2'b00, 1};
        vecs[7] = '{"saturate", 2'b01, 7'h71, 20, 2'b10, 7'h6F, 20, 2'b10, 7'h6F, 1, 8'h9F, 1'b0, 2'b00, 1};

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seg_in    = 7'($urandom);
            digit_sel = 2'($urandom);
            @(negedge clk);
            check("rst_dout",   32'(dout),       32'h0);
            check("rst_valid",  32'(dout_valid), 32'h0);
            check("rst_err",    32'(dout_err),   32'h0);
            check("rst_mask",   32'(err_mask),   32'h0);
        end
        rst = 1'b0;
        hold(2'b00, SEG_BLANK, 3);

        // Frame table
        for (int v = 0; v < 8; v++) begin
            p0 = pulse_total;
            hold(vecs[v].sel0, vecs[v].seg0, vecs[v].n0);
            hold(vecs[v].sel1, vecs[v].seg1, vecs[v].n1);
            hold(vecs[v].sel2, vecs[v].seg2, vecs[v].n2);
            repeat (2) @(negedge clk);
            check({vecs[v].name, "_pulses"}, 32'(pulse_total - p0), 32'(vecs[v].exp_pulses));
            check({vecs[v].name, "_dout"},   32'(dout),     32'(vecs[v].exp_dout));
            check({vecs[v].name, "_err"},    32'(dout_err), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_mask"},   32'(err_mask), 32'(vecs[v].exp_mask));
        end

        // Exact latency and one-cycle pulse width
        hold(2'b01, 7'h66, 6);
        hold(2'b10, 7'h7D, 5);
        check("lat_early_valid", 32'(dout_valid), 32'h0);
        @(negedge clk);
        check("lat_valid", 32'(dout_valid), 32'h1);
        check("lat_dout",  32'(dout),       32'h64);
        @(negedge clk);
        check("lat_pulse_width", 32'(dout_valid), 32'h0);

        // Reset mid-frame discards the captured digit 0
        p0 = pulse_total;
        hold(2'b01, 7'h79, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(2'b10, 7'h71, 6);
        check("midrst_nopulse", 32'(pulse_total - p0), 32'h0);
        hold(2'b01, 7'h77, 6);
        repeat (2) @(negedge clk);
        check("midrst_pulses", 32'(pulse_total - p0), 32'h1);
        check("midrst_dout",   32'(dout),     32'hFA);
        check("midrst_err",    32'(dout_err), 32'h0);
        check("midrst_mask",   32'(err_mask), 32'h0);

        // Reset on the completing edge wins
        hold(2'b01, 7'h3F, 6);
        p0 = pulse_total;
        hold(2'b10, 7'h06, 5);
        rst = 1'b1;
        @(negedge clk);
        check("race_valid", 32'(dout_valid), 32'h0);
        check("race_dout",  32'(dout),       32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("race_pulses", 32'(pulse_total - p0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seven_seg_capture
`default_nettype wire
